line_edge_renderer: RTL and testbench

//  Multi-line successor of the single-edge test-pattern colourer: rasterises N_LINES

---
 rtl/line_render_pkg.sv | 34 +++
 rtl/line_edge_renderer_if.sv | 18 +
 rtl/line_stepper.sv | 93 +++++++++
 rtl/line_edge_renderer.sv | 173 +++++++++++++++++
 tb/tb_line_edge_renderer.sv | 176 +++++++++++++++++
 5 files changed

// File: rtl/line_render_pkg.sv
// Shared types for the multi-line edge renderer: paint modes, colours, row-buffer
// entries and the render-FSM states.
package line_render_pkg;

  localparam int unsigned LR_X_W = 11;

  typedef enum logic [1:0] {
    PM_OFF        = 2'b00,
    PM_FILL_RIGHT = 2'b01,
    PM_SPAN       = 2'b10,
    PM_FILL_LEFT  = 2'b11
  } paint_mode_e;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb_t;

  typedef struct packed {
    logic              valid;
    logic [LR_X_W-1:0] min_x;
    logic [LR_X_W-1:0] max_x;
  } row_entry_t;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CLEAR,
    ST_SETUP,
    ST_STEP,
    ST_DONE
  } state_e;

endpackage

// File: rtl/line_edge_renderer_if.sv
// Render-control bundle: start/busy/done handshake plus per-line endpoints and colours.
interface line_edge_renderer_if #(
  parameter int unsigned N_LINES = 2,
  parameter int unsigned X_W     = 11,
  parameter int unsigned Y_W     = 10
) ();
  logic                   start;
  logic                   busy;
  logic                   done;
  logic [N_LINES*X_W-1:0] x0;
  logic [N_LINES*X_W-1:0] x1;
  logic [N_LINES*Y_W-1:0] y0;
  logic [N_LINES*Y_W-1:0] y1;
  logic [N_LINES*24-1:0]  line_rgb;

  modport master (output start, x0, x1, y0, y1, line_rgb, input busy, done);
  modport slave  (input start, x0, x1, y0, y1, line_rgb, output busy, done);
endinterface

// File: rtl/line_stepper.sv
// Bresenham engine for one line: one point per step, emits one commit per row with the
// x extent of that row. Endpoints are ordered so y only ever increases.
module line_stepper #(
  parameter int unsigned X_W = 11,
  parameter int unsigned Y_W = 10
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           load,
  input  logic           step,
  input  logic [X_W-1:0] x0,
  input  logic [X_W-1:0] x1,
  input  logic [Y_W-1:0] y0,
  input  logic [Y_W-1:0] y1,
  output logic           row_commit,
  output logic [Y_W-1:0] commit_y,
  output logic [X_W-1:0] commit_min,
  output logic [X_W-1:0] commit_max,
  output logic           last
);
  localparam int unsigned E_W = X_W + 2;

  logic [X_W-1:0] x_q, x_d, xe_q, xe_d, dx_q, dx_d, min_q, min_d, max_q, max_d;
  logic [Y_W-1:0] y_q, y_d, ye_q, ye_d, dy_q, dy_d;
  logic           sx_q, sx_d, fresh_q, fresh_d;
  logic signed [E_W-1:0] err_q, err_d;

  logic signed [X_W+2:0] e2, dxs, dys, errx, nerr;
  logic                  mv_x, mv_y, swap;
  logic [X_W-1:0]        xa, xb, cur_min, cur_max;
  logic [Y_W-1:0]        ya, yb;

  always_comb begin
    x_d = x_q;  xe_d = xe_q;  dx_d = dx_q;  min_d = min_q;  max_d = max_q;
    y_d = y_q;  ye_d = ye_q;  dy_d = dy_q;  sx_d = sx_q;  fresh_d = fresh_q;
    err_d = err_q;

    last = (x_q == xe_q) && (y_q == ye_q);
    errx = (X_W+3)'(err_q);
    e2   = $signed({err_q, 1'b0});
    dxs  = $signed((X_W+3)'(dx_q));
    dys  = $signed((X_W+3)'(dy_q));
    // strict compares place the y step after the first x run (row k holds 2k..2k+1 for 2:1)
    mv_x = e2 > -dys;
    mv_y = e2 < dxs;
    nerr = errx - (mv_x ? dys : '0) + (mv_y ? dxs : '0);

    cur_min = (fresh_q || x_q < min_q) ? x_q : min_q;
    cur_max = (fresh_q || x_q > max_q) ? x_q : max_q;

    row_commit = step && (last || mv_y);
    commit_y   = y_q;
    commit_min = cur_min;
    commit_max = cur_max;

    swap = y0 > y1;
    xa   = swap ? x1 : x0;
    xb   = swap ? x0 : x1;
    ya   = swap ? y1 : y0;
    yb   = swap ? y0 : y1;

    if (load) begin
      x_d     = xa;
      y_d     = ya;
      xe_d    = xb;
      ye_d    = yb;
      sx_d    = xb < xa;
      dx_d    = (xb < xa) ? (xa - xb) : (xb - xa);
      dy_d    = yb - ya;
      err_d   = $signed(E_W'(dx_d)) - $signed(E_W'(dy_d));
      fresh_d = 1'b1;
    end else if (step && !last) begin
      x_d     = mv_x ? (sx_q ? x_q - X_W'(1) : x_q + X_W'(1)) : x_q;
      y_d     = mv_y ? y_q + Y_W'(1) : y_q;
      err_d   = $signed(nerr[E_W-1:0]);
      fresh_d = mv_y;
      min_d   = cur_min;
      max_d   = cur_max;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      x_q <= '0;  xe_q <= '0;  dx_q <= '0;  min_q <= '0;  max_q <= '0;
      y_q <= '0;  ye_q <= '0;  dy_q <= '0;  sx_q <= 1'b0;  fresh_q <= 1'b1;
      err_q <= '0;
    end else begin
      x_q <= x_d;  xe_q <= xe_d;  dx_q <= dx_d;  min_q <= min_d;  max_q <= max_d;
      y_q <= y_d;  ye_q <= ye_d;  dy_q <= dy_d;  sx_q <= sx_d;  fresh_q <= fresh_d;
      err_q <= err_d;
    end
  end
endmodule

// File: rtl/line_edge_renderer.sv
// Rasterises N_LINES lines into per-row edge buffers, then colours each pixel against
// those edges with a two-cycle read/register pixel path.
module line_edge_renderer
  import line_render_pkg::*;
#(
  parameter int unsigned N_LINES = 2,
  parameter int unsigned X_W     = LR_X_W,
  parameter int unsigned Y_W     = 10,
  parameter int unsigned V_ROWS  = 480
) (
  input  logic                 clk,
  input  logic                 reset,
  line_edge_renderer_if.slave  ctl,
  input  logic [23:0]          bg_rgb,
  input  logic [1:0]           mode,
  input  logic [X_W-1:0]       Xpos,
  input  logic [Y_W-1:0]       Ypos,
  output logic [7:0]           red,
  output logic [7:0]           green,
  output logic [7:0]           blue
);
  localparam int unsigned A_W = $clog2(V_ROWS);
  localparam int unsigned LW  = (N_LINES > 1) ? $clog2(N_LINES) : 1;
  localparam logic [LW-1:0]  LAST_LINE = LW'(N_LINES - 1);
  localparam logic [A_W-1:0] LAST_ROW  = A_W'(V_ROWS - 1);
  localparam logic [Y_W-1:0] ROWS_Y    = Y_W'(V_ROWS);

  state_e                 state_q, state_d;
  logic [A_W-1:0]         clr_q, clr_d;
  logic [LW-1:0]          line_q, line_d;
  logic                   fv_q, fv_d;
  logic [N_LINES*X_W-1:0] lx0_q, lx0_d, lx1_q, lx1_d;
  logic [N_LINES*Y_W-1:0] ly0_q, ly0_d, ly1_q, ly1_d;
  logic [N_LINES*24-1:0]  lrgb_q, lrgb_d;

  logic                   load, step, commit, last, busy;
  logic [Y_W-1:0]         cy;
  logic [X_W-1:0]         cmin, cmax;
  int unsigned            lbx, lby;

  logic                   wr_en, wr_all;
  logic [LW-1:0]          wr_line;
  logic [A_W-1:0]         wr_addr, rd_addr;
  row_entry_t             wr_data;

  assign lbx = 32'(line_q) * X_W;
  assign lby = 32'(line_q) * Y_W;

  line_stepper #(.X_W(X_W), .Y_W(Y_W)) u_stepper (
    .clk        (clk),
    .reset      (reset),
    .load       (load),
    .step       (step),
    .x0         (lx0_q[lbx +: X_W]),
    .x1         (lx1_q[lbx +: X_W]),
    .y0         (ly0_q[lby +: Y_W]),
    .y1         (ly1_q[lby +: Y_W]),
    .row_commit (commit),
    .commit_y   (cy),
    .commit_min (cmin),
    .commit_max (cmax),
    .last       (last)
  );

  assign busy     = (state_q != ST_IDLE);
  assign ctl.busy = busy;
  assign ctl.done = (state_q == ST_DONE);

  always_comb begin
    state_d = state_q;  clr_d = clr_q;  line_d = line_q;  fv_d = fv_q;
    lx0_d = lx0_q;  lx1_d = lx1_q;  ly0_d = ly0_q;  ly1_d = ly1_q;  lrgb_d = lrgb_q;
    load = 1'b0;  step = 1'b0;
    wr_en = 1'b0;  wr_all = 1'b0;  wr_line = line_q;
    wr_addr = cy[A_W-1:0];
    wr_data = row_entry_t'{valid: 1'b1, min_x: cmin, max_x: cmax};

    case (state_q)
      ST_IDLE: if (ctl.start) begin
        lx0_d = ctl.x0;  lx1_d = ctl.x1;  ly0_d = ctl.y0;  ly1_d = ctl.y1;
        lrgb_d = ctl.line_rgb;
        clr_d = '0;  line_d = '0;
        state_d = ST_CLEAR;
      end
      ST_CLEAR: begin
        wr_en = 1'b1;  wr_all = 1'b1;  wr_addr = clr_q;  wr_data = '0;
        if (clr_q == LAST_ROW) state_d = ST_SETUP;
        else clr_d = clr_q + A_W'(1);
      end
      ST_SETUP: begin
        load = 1'b1;
        state_d = ST_STEP;
      end
      ST_STEP: begin
        step  = 1'b1;
        // rows past the buffer keep stepping but never write (would alias low rows)
        wr_en = commit && (cy < ROWS_Y);
        if (last) begin
          if (line_q == LAST_LINE) state_d = ST_DONE;
          else begin
            line_d  = line_q + LW'(1);
            state_d = ST_SETUP;
          end
        end
      end
      ST_DONE: begin
        fv_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Pixel path stage 1: buffer read with aligned Xpos/mode; stage 2: colour register.
  logic           yok_q, yok_d;
  logic [X_W-1:0] xpos_q;
  paint_mode_e    mode_q;
  rgb_t           rgb_q, rgb_d;
  logic [N_LINES-1:0] hit;

  assign yok_d   = (Ypos < ROWS_Y);
  assign rd_addr = yok_d ? Ypos[A_W-1:0] : '0;

  for (genvar g = 0; g < N_LINES; g++) begin : g_buf
    row_entry_t mem [V_ROWS];
    row_entry_t rd_q;
    logic       h;

    always_ff @(posedge clk) begin
      if (wr_en && (wr_all || wr_line == LW'(g))) mem[wr_addr] <= wr_data;
      rd_q <= mem[rd_addr];
    end

    always_comb begin
      case (mode_q)
        PM_FILL_RIGHT: h = rd_q.valid && (xpos_q >= rd_q.min_x);
        PM_SPAN:       h = rd_q.valid && (xpos_q >= rd_q.min_x) && (xpos_q <= rd_q.max_x);
        PM_FILL_LEFT:  h = rd_q.valid && (xpos_q <= rd_q.max_x);
        default:       h = 1'b0;
      endcase
    end
    assign hit[g] = h;
  end

  always_comb begin
    logic found;
    found = 1'b0;
    rgb_d = rgb_t'(bg_rgb);
    if (!busy && fv_q && yok_q) begin
      for (int unsigned i = 0; i < N_LINES; i++) begin
        if (!found && hit[i]) begin
          rgb_d = rgb_t'(lrgb_q[i*24 +: 24]);
          found = 1'b1;
        end
      end
    end
  end

  assign red   = rgb_q.r;
  assign green = rgb_q.g;
  assign blue  = rgb_q.b;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;  clr_q <= '0;  line_q <= '0;  fv_q <= 1'b0;
      lx0_q <= '0;  lx1_q <= '0;  ly0_q <= '0;  ly1_q <= '0;  lrgb_q <= '0;
      yok_q <= 1'b0;  xpos_q <= '0;  mode_q <= PM_OFF;  rgb_q <= '0;
    end else begin
      state_q <= state_d;  clr_q <= clr_d;  line_q <= line_d;  fv_q <= fv_d;
      lx0_q <= lx0_d;  lx1_q <= lx1_d;  ly0_q <= ly0_d;  ly1_q <= ly1_d;  lrgb_q <= lrgb_d;
      yok_q <= yok_d;  xpos_q <= Xpos;  mode_q <= paint_mode_e'(mode);  rgb_q <= rgb_d;
    end
  end
endmodule

// File: tb/tb_line_edge_renderer.sv
// Directed bench for line_edge_renderer: render-time, row-extent and pixel-colour checks.
module tb_line_edge_renderer;
  localparam int unsigned N = 2, XW = 11, YW = 10;
  localparam logic [23:0] BG = 24'h102030, C0 = 24'hFF0000, C1 = 24'h00FF00;
  localparam logic [1:0]  OFF = 2'b00, FR = 2'b01, SP = 2'b10, FL = 2'b11;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic [23:0]   bg_rgb;
  logic [1:0]    mode;
  logic [XW-1:0] Xpos;
  logic [YW-1:0] Ypos;
  logic [7:0]    red, green, blue;
  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  line_edge_renderer_if #(.N_LINES(N), .X_W(XW), .Y_W(YW)) ctl ();

  line_edge_renderer #(.N_LINES(N), .X_W(XW), .Y_W(YW), .V_ROWS(480)) dut (
    .clk    (clk),
    .reset  (reset),
    .ctl    (ctl),
    .bg_rgb (bg_rgb),
    .mode   (mode),
    .Xpos   (Xpos),
    .Ypos   (Ypos),
    .red    (red),
    .green  (green),
    .blue   (blue)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lines(input int ax0, ay0, ax1, ay1, bx0, by0, bx1, by1);
    ctl.x0 = {XW'(bx0), XW'(ax0)};
    ctl.y0 = {YW'(by0), YW'(ay0)};
    ctl.x1 = {XW'(bx1), XW'(ax1)};
    ctl.y1 = {YW'(by1), YW'(ay1)};
  endtask

  task automatic pix(input string tag, input int x, input int y, input logic [1:0] m,
                     input logic [23:0] exp);
    Xpos = XW'(x);  Ypos = YW'(y);  mode = m;
    repeat (2) @(posedge clk);
    #1;
    check(tag, {8'h00, red, green, blue}, {8'h00, exp});
  endtask

  // Pulses start and counts edges (start edge = 1) until done; optionally re-pulses
  // start with other endpoints while busy.
  task automatic run(input string tag, input int exp_cyc, input bit glitch);
    int cyc;
    bit seen;
    cyc = 0;  seen = 1'b0;
    ctl.start = 1'b1;
    for (int k = 0; k < 3000 && !seen; k++) begin
      @(posedge clk);
      #1;
      cyc++;
      if (k == 0) begin
        ctl.start = 1'b0;
        check({tag, "_busy"}, 32'(ctl.busy), 32'd1);
      end
      if (glitch && k == 10) begin
        set_lines(50, 300, 50, 310, 60, 100, 60, 110);
        ctl.start = 1'b1;
      end
      if (glitch && k == 11) ctl.start = 1'b0;
      if (ctl.done) seen = 1'b1;
    end
    check({tag, "_cycles"}, seen ? 32'(cyc) : 32'd0, 32'(exp_cyc));
    @(posedge clk);
    #1;
    check({tag, "_done_pulse"}, 32'(ctl.done), 32'd0);
    check({tag, "_idle"}, 32'(ctl.busy), 32'd0);
  endtask

  initial begin
    ctl.start = 1'b0;
    ctl.line_rgb = {C1, C0};
    bg_rgb = BG;  mode = FR;  Xpos = '0;  Ypos = '0;
    set_lines(0, 0, 600, 300, 0, 500, 0, 500);
    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", 32'(ctl.busy), 32'd0);
    check("rst_done", 32'(ctl.done), 32'd0);
    check("rst_rgb", {8'h00, red, green, blue}, 32'd0);
    reset = 1'b1;

    // 1: reset in the middle of stepping
    ctl.start = 1'b1;
    @(posedge clk);
    #1;
    ctl.start = 1'b0;
    repeat (700) @(posedge clk);
    #1;
    reset = 1'b0;
    #1;
    check("midrst_busy", 32'(ctl.busy), 32'd0);
    check("midrst_rgb", {8'h00, red, green, blue}, 32'd0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    pix("midrst_bg", 200, 100, FR, BG);

    // 2: (0,0)-(600,300); line 1 is a point below the buffer (2 cycles)
    run("t2", 480 + 602 + 2 + 1, 1'b0);
    pix("t2_fr_199", 199, 100, FR, BG);
    pix("t2_fr_200", 200, 100, FR, C0);
    pix("t2_fr_far", 2000, 100, FR, C0);
    pix("t2_sp_201", 201, 100, SP, C0);
    pix("t2_sp_202", 202, 100, SP, BG);
    pix("t2_fl_201", 201, 100, FL, C0);
    pix("t2_fl_202", 202, 100, FL, BG);
    pix("t2_off", 200, 100, OFF, BG);
    pix("t2_row0_1", 1, 0, SP, C0);
    pix("t2_row0_2", 2, 0, SP, BG);
    pix("t2_end", 600, 300, SP, C0);
    pix("t2_y500", 0, 500, FR, BG);

    // 3: overlap on row 50, lower index wins
    set_lines(100, 50, 300, 50, 150, 40, 150, 60);
    run("t3", 480 + 202 + 22 + 1, 1'b0);
    pix("t3_overlap", 150, 50, SP, C0);
    pix("t3_line1", 150, 45, SP, C1);
    pix("t3_right", 350, 50, SP, BG);
    pix("t3_below", 150, 61, SP, BG);
    pix("t3_fr160", 160, 40, FR, C1);
    pix("t3_fr140", 140, 40, FR, BG);

    // 4: horizontal drawn right-to-left
    set_lines(500, 20, 100, 20, 0, 500, 0, 500);
    run("t4", 480 + 402 + 2 + 1, 1'b0);
    pix("t4_lo", 100, 20, SP, C0);
    pix("t4_hi", 500, 20, SP, C0);
    pix("t4_lo_out", 99, 20, SP, BG);
    pix("t4_hi_out", 501, 20, SP, BG);
    pix("t4_row21", 300, 21, SP, BG);
    pix("t4_row19", 300, 19, SP, BG);

    // 5: vertical line crossing the bottom of the buffer
    set_lines(10, 470, 10, 520, 0, 500, 0, 500);
    run("t5", 480 + 52 + 2 + 1, 1'b0);
    pix("t5_479", 10, 479, SP, C0);
    pix("t5_470", 10, 470, SP, C0);
    pix("t5_469", 10, 469, SP, BG);
    pix("t5_fr9", 9, 479, FR, BG);
    pix("t5_fl_479", 10, 479, FL, C0);
    pix("t5_y500", 10, 500, FL, BG);
    pix("t5_alias", 10, 5, SP, BG);

    // 6: reversed endpoints; start re-pulsed while busy with other endpoints
    set_lines(300, 210, 300, 200, 0, 500, 0, 500);
    run("t6", 480 + 12 + 2 + 1, 1'b1);
    pix("t6_old", 300, 205, SP, C0);
    pix("t6_old_top", 300, 200, SP, C0);
    pix("t6_new", 50, 305, SP, BG);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1);
  end
endmodule
